// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 pipeline: CSR read/modify/write, trap entry, mret,
// and optional 64-bit mcycle/minstret counters (enabled by defining CSR_COUNTERS_EN).
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic        csr_wnull,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] cycle_lo;
  logic [XLEN-1:0] cycle_hi;
  logic [XLEN-1:0] instret_lo;
  logic [XLEN-1:0] instret_hi;

  logic            mapped;
  logic            read_only;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            is_write;
  logic            wr_en;

  // Address decode and read mux (old value, before this cycle's write)
  always_comb begin
    mapped    = 1'b1;
    read_only = 1'b0;
    old_val   = '0;
    case (csr_addr)
      ADDR_MSTATUS:  old_val = {24'b0, mpie, 3'b0, mie, 3'b0};
      ADDR_MTVEC:    old_val = mtvec;
      ADDR_MSCRATCH: old_val = mscratch;
      ADDR_MEPC:     old_val = mepc;
      ADDR_MCAUSE:   old_val = mcause;
      ADDR_MHARTID: begin
        old_val   = HART_ID;
        read_only = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    old_val = cycle_lo;
      ADDR_MCYCLEH:   old_val = cycle_hi;
      ADDR_MINSTRET:  old_val = instret_lo;
      ADDR_MINSTRETH: old_val = instret_hi;
`endif
      default:       mapped = 1'b0;
    endcase
  end

  // Write-value computation, legality check and write enable
  always_comb begin
    is_write = (csr_op == OP_RW) || (((csr_op == OP_RS) || (csr_op == OP_RC)) && !csr_wnull);
    case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
    csr_illegal = csr_en && (!mapped || (read_only && is_write));
    csr_rdata   = (csr_en && !csr_illegal) ? old_val : '0;
    wr_en       = csr_en && !csr_illegal && !trap_req && is_write;
  end

  // Architectural CSR state: CSR writes, then mret, then trap (trap overrides all)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN_MASK;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie  <= new_val[3];
            mpie <= new_val[7];
          end
          ADDR_MTVEC:    mtvec    <= new_val & ALIGN_MASK;
          ADDR_MSCRATCH: mscratch <= new_val;
          ADDR_MEPC:     mepc     <= new_val & ALIGN_MASK;
          ADDR_MCAUSE:   mcause   <= new_val;
          default:       ;
        endcase
      end
      if (mret && !trap_req) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
      if (trap_req) begin
        mepc   <= trap_pc & ALIGN_MASK;
        mcause <= trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic wr_cyc_lo;
  logic wr_cyc_hi;
  logic wr_ret_lo;
  logic wr_ret_hi;

  assign wr_cyc_lo = wr_en && (csr_addr == ADDR_MCYCLE);
  assign wr_cyc_hi = wr_en && (csr_addr == ADDR_MCYCLEH);
  assign wr_ret_lo = wr_en && (csr_addr == ADDR_MINSTRET);
  assign wr_ret_hi = wr_en && (csr_addr == ADDR_MINSTRETH);

  // 64-bit counters; a written half wins, and a written low half drops its carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_lo   <= '0;
      cycle_hi   <= '0;
      instret_lo <= '0;
      instret_hi <= '0;
    end else begin
      if (wr_cyc_lo)      cycle_lo <= new_val;
      else                cycle_lo <= cycle_lo + XLEN'(1);
      if (wr_cyc_hi)      cycle_hi <= new_val;
      else if (!wr_cyc_lo && (&cycle_lo)) cycle_hi <= cycle_hi + XLEN'(1);

      if (wr_ret_lo)      instret_lo <= new_val;
      else if (instr_retire) instret_lo <= instret_lo + XLEN'(1);
      if (wr_ret_hi)      instret_hi <= new_val;
      else if (!wr_ret_lo && instr_retire && (&instret_lo)) instret_hi <= instret_hi + XLEN'(1);
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
  assign cycle_lo   = '0;
  assign cycle_hi   = '0;
  assign instret_lo = '0;
  assign instret_hi = '0;
`endif

  assign trap_vector = mtvec;
  assign mepc_out    = mepc;
  assign mie_out     = mie;

endmodule
